datapath_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one instance of the combinational 6-bit-in / 20-bit-out datapath between `NUM_REQ` requesters. It accepts one operand at a time over valid/ready, holds it stable on the datapath input, samples the result after a programmable settle time, and returns it with the requester's ID over a back-pressured response channel. It sits between the requester ports and the datapath instance, which it connects to through `dp_in`/`dp_out`.

---
 rtl/datapath_sched_pkg.sv | 39 +++
 rtl/datapath_rr_scheduler_arb.sv | 25 ++
 rtl/datapath_rr_scheduler.sv | 121 ++++++++++++
 tb/tb_datapath_rr_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_sched_pkg.sv
// Shared types, default widths and the round-robin pick helper for the scheduler.
package datapath_sched_pkg;

    localparam int unsigned IN_W    = 6;
    localparam int unsigned OUT_W   = 20;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of valid searching ptr, ptr+1, ... with wrap at num.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int unsigned        num);
        pick_t       p;
        int unsigned pos;
        p = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= num) pos = pos - num;
            if (!p.found && (k < num) && valid[IDX_W'(pos)]) begin
                p.found = 1'b1;
                p.idx   = IDX_W'(pos);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/datapath_rr_scheduler_arb.sv
// Combinational round-robin arbiter: one-hot grant plus encoded winner index.
module rr_arbiter
    import datapath_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    pick_t pick;

    // Search from the pointer and expand the winner into a one-hot grant.
    always_comb begin
        pick  = rr_pick(MAX_REQ'(valid_i), IDX_W'(ptr_i), NUM_REQ);
        any_o = pick.found;
        idx_o = ID_W'(pick.idx);
        gnt_o = pick.found ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/datapath_rr_scheduler.sv
// Shares one combinational datapath between NUM_REQ requesters in round-robin order.
module datapath_rr_scheduler #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned IN_W    = datapath_sched_pkg::IN_W,
    parameter  int unsigned OUT_W   = datapath_sched_pkg::OUT_W,
    parameter  int unsigned DP_LAT  = 1,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [IN_W-1:0]         dp_in,
    input  logic [OUT_W-1:0]        dp_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUT_W-1:0]        rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    import datapath_sched_pkg::*;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [IN_W-1:0]    dp_in_q, dp_in_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               busy_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Next-state, grant and datapath-capture decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        dp_in_d     = dp_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (!rst && arb_any) req_ready = arb_gnt;
                if (arb_any) begin
                    dp_in_d = req_data[32'(arb_idx)*IN_W +: IN_W];
                    id_d    = arb_idx;
                    ptr_d   = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + ID_W'(1);
                    cnt_d   = CNT_W'(DP_LAT);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d  = dp_out;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            id_q        <= '0;
            dp_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            dp_in_q     <= dp_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign dp_in     = dp_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_datapath_rr_scheduler.sv
// Bench for datapath_rr_scheduler: unit 0 with DP_LAT=1, unit 1 with DP_LAT=4.
module tb_datapath_rr_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 6;
    localparam int unsigned OW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [1:0][N-1:0]      valid;
    logic [1:0][N-1:0]      ready;
    logic [1:0][N*IW-1:0]   data;
    logic [1:0][IW-1:0]     dpin;
    logic [1:0][OW-1:0]     dpout;
    logic [1:0][OW-1:0]     rdata;
    logic [1:0][1:0]        rid;
    logic [1:0]             rvalid;
    logic [1:0]             rready;
    logic [1:0]             busy;

    // Stub datapath: result is three times the operand.
    assign dpout[0] = OW'(dpin[0]) * OW'(3);
    assign dpout[1] = OW'(dpin[1]) * OW'(3);

    datapath_rr_scheduler #(.NUM_REQ(4), .DP_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_data(data[0]), .dp_in(dpin[0]), .dp_out(dpout[0]),
        .rsp_valid(rvalid[0]), .rsp_ready(rready[0]), .rsp_data(rdata[0]),
        .rsp_id(rid[0]), .busy(busy[0])
    );

    datapath_rr_scheduler #(.NUM_REQ(4), .DP_LAT(4)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_data(data[1]), .dp_in(dpin[1]), .dp_out(dpout[1]),
        .rsp_valid(rvalid[1]), .rsp_ready(rready[1]), .rsp_data(rdata[1]),
        .rsp_id(rid[1]), .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Transaction-level model state per unit.
    bit m_busy  [2];
    int m_age   [2];
    int m_ptr   [2];
    int m_op    [2];
    int m_id    [2];
    int m_rdata [2];
    int m_rid   [2];

    // Observed grants, grant cycles and handshaken results of unit 0.
    int g_log [$];
    int g_cyc [$];
    int r_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Compare every unit against the model, then advance the model over the next edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                int g;
                bit erv;
                logic [N-1:0] erdy;
                erv  = m_busy[u] && (m_age[u] >= lat_of(u));
                g    = (rst || m_busy[u]) ? -1 : pick(valid[u], m_ptr[u]);
                erdy = (g < 0) ? '0 : (N'(1) << g);
                chk($sformatf("u%0d_req_ready", u), 32'(ready[u]), 32'(erdy));
                chk($sformatf("u%0d_dp_in", u), 32'(dpin[u]), 32'(m_op[u]));
                chk($sformatf("u%0d_rsp_valid", u), 32'(rvalid[u]), 32'(erv));
                chk($sformatf("u%0d_rsp_data", u), 32'(rdata[u]), 32'(m_rdata[u]));
                chk($sformatf("u%0d_rsp_id", u), 32'(rid[u]), 32'(m_rid[u]));
                chk($sformatf("u%0d_busy", u), 32'(busy[u]), 32'(m_busy[u]));
                if (u == 0 && !rst) begin
                    if ((valid[0] & ready[0]) != '0) begin
                        for (int k = 0; k < N; k++)
                            if (ready[0][k]) g_log.push_back(k);
                        g_cyc.push_back(cyc);
                    end
                    if (rvalid[0] && rready[0]) r_log.push_back(int'(rdata[0]));
                end
                if (rst) begin
                    m_busy[u] = 1'b0; m_age[u] = 0; m_ptr[u] = 0; m_op[u] = 0;
                    m_id[u] = 0; m_rdata[u] = 0; m_rid[u] = 0;
                end else if (!m_busy[u]) begin
                    if (g >= 0) begin
                        m_busy[u] = 1'b1;
                        m_age[u]  = 0;
                        m_op[u]   = int'(data[u][g*IW +: IW]);
                        m_id[u]   = g;
                        m_ptr[u]  = (g + 1) % N;
                    end
                end else if (erv) begin
                    if (rready[u]) m_busy[u] = 1'b0;
                end else begin
                    m_age[u]++;
                    if (m_age[u] == lat_of(u)) begin
                        m_rdata[u] = 3 * m_op[u];
                        m_rid[u]   = m_id[u];
                    end
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        valid  = '0;
        data   = '0;
        rready = 2'b11;
        tick();
        chk_en = 1'b1;
        valid[0] = 4'hF;
        #1;
        chk("rst_ready_low", 32'(ready[0]), 32'(0));
        valid[0] = '0;
        tick();
        rst = 1'b0;

        // Requester 2 alone, DP_LAT=1.
        data[0][2*IW +: IW] = 6'd5;
        valid[0] = 4'b0100;
        #1;
        chk("t1_grant", 32'(ready[0]), 32'(4'b0100));
        tick();
        valid[0] = '0;
        chk("t1_settle_valid", 32'(rvalid[0]), 32'(0));
        chk("t1_busy", 32'(busy[0]), 32'(1));
        tick();
        chk("t1_rsp_valid", 32'(rvalid[0]), 32'(1));
        chk("t1_rsp_data", 32'(rdata[0]), 32'(15));
        chk("t1_rsp_id", 32'(rid[0]), 32'(2));
        tick();
        chk("t1_done", 32'(rvalid[0]), 32'(0));

        // All four requesting continuously from ptr 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) data[0][i*IW +: IW] = IW'(i + 1);
        g_log.delete(); g_cyc.delete(); r_log.delete();
        valid[0] = 4'hF;
        repeat (13) tick();
        valid[0] = '0;
        repeat (3) tick();
        chk("t2_ngrants", 32'(g_log.size()), 32'(5));
        chk("t2_nrsp", 32'(r_log.size()), 32'(5));
        if (g_log.size() == 5 && r_log.size() == 5) begin
            chk("t2_g0", 32'(g_log[0]), 32'(0));
            chk("t2_g1", 32'(g_log[1]), 32'(1));
            chk("t2_g2", 32'(g_log[2]), 32'(2));
            chk("t2_g3", 32'(g_log[3]), 32'(3));
            chk("t2_g4", 32'(g_log[4]), 32'(0));
            chk("t2_r0", 32'(r_log[0]), 32'(3));
            chk("t2_r1", 32'(r_log[1]), 32'(6));
            chk("t2_r2", 32'(r_log[2]), 32'(9));
            chk("t2_r3", 32'(r_log[3]), 32'(12));
            for (int i = 1; i < 5; i++)
                chk("t2_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(3));
        end

        // DP_LAT=4 unit: operand 63 held through the settle window.
        data[1][0 +: IW] = 6'd63;
        valid[1] = 4'b0001;
        tick();
        valid[1] = '0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_dp_in_hold", 32'(dpin[1]), 32'(63));
            chk("t3_no_rsp_yet", 32'(rvalid[1]), 32'(0));
            tick();
        end
        chk("t3_rsp_valid", 32'(rvalid[1]), 32'(1));
        chk("t3_rsp_data", 32'(rdata[1]), 32'(189));
        chk("t3_dp_in_resp", 32'(dpin[1]), 32'(63));
        tick();
        chk("t3_done", 32'(rvalid[1]), 32'(0));

        // Back-pressure in RESP with requests 1 and 3 pending (ptr is 1).
        rready[0] = 1'b0;
        data[0][1*IW +: IW] = 6'd10;
        data[0][3*IW +: IW] = 6'd20;
        valid[0] = 4'b1010;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t4_no_ready", 32'(ready[0]), 32'(0));
            chk("t4_busy", 32'(busy[0]), 32'(1));
            chk("t4_rsp_data", 32'(rdata[0]), 32'(30));
            chk("t4_rsp_id", 32'(rid[0]), 32'(1));
            tick();
        end
        rready[0] = 1'b1;
        tick();
        chk("t4_next_grant", 32'(ready[0]), 32'(4'b1000));
        tick();
        valid[0] = '0;
        tick();
        chk("t4_rsp3_data", 32'(rdata[0]), 32'(60));
        chk("t4_rsp3_id", 32'(rid[0]), 32'(3));
        tick();

        // Reset during SETTLE discards the pending result and clears ptr.
        data[0][2*IW +: IW] = 6'd7;
        valid[0] = 4'b0100;
        tick();
        valid[0] = '0;
        rst = 1'b1;
        tick();
        chk("t5_rsp_valid", 32'(rvalid[0]), 32'(0));
        chk("t5_dp_in", 32'(dpin[0]), 32'(0));
        chk("t5_rsp_data", 32'(rdata[0]), 32'(0));
        chk("t5_rsp_id", 32'(rid[0]), 32'(0));
        chk("t5_busy", 32'(busy[0]), 32'(0));
        rst = 1'b0;
        tick();
        chk("t5_no_pulse", 32'(rvalid[0]), 32'(0));
        data[0][0 +: IW] = 6'd9;
        valid[0] = 4'b1001;
        #1;
        chk("t5_ptr0_grant", 32'(ready[0]), 32'(4'b0001));
        tick();
        valid[0] = '0;
        tick();
        chk("t5_rsp_data0", 32'(rdata[0]), 32'(27));
        tick();

        // Requester 1 pulses while 0 is served; then 3 wins over 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        data[0][0 +: IW]    = 6'd4;
        data[0][3*IW +: IW] = 6'd11;
        valid[0] = 4'b0001;
        tick();
        valid[0] = 4'b0010;
        tick();
        valid[0] = 4'b1001;
        #1;
        chk("t6_resp_no_ready", 32'(ready[0]), 32'(0));
        tick();
        chk("t6_grant3", 32'(ready[0]), 32'(4'b1000));
        tick();
        valid[0] = '0;
        tick();
        chk("t6_rsp_id", 32'(rid[0]), 32'(3));
        chk("t6_rsp_data", 32'(rdata[0]), 32'(33));
        tick();
        if (g_log.size() >= 2) begin
            chk("t6_last_g", 32'(g_log[g_log.size()-1]), 32'(3));
            chk("t6_prev_g", 32'(g_log[g_log.size()-2]), 32'(0));
        end else begin
            chk("t6_glog_len", 32'(g_log.size()), 32'(2));
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
